fft_stage_sequencer: RTL
========================

// Module: fft_stage_sequencer
// PURPOSE
//  Frame sequencer for the pipelined radix FFT datapath. Accepts one ARRAY-wide
//  input beat per cycle via valid/ready and emits a per-stage enable train.
//  Also emits a per-stage in-frame index that drives the twiddle-segment
//  selection of each stage's multiplier.
//  Sits between the input sample buffer and the butterfly/twiddle stages.
//  Signals frame completion to the output reorder buffer.
// PARAMETERS
//  NSTAGE    = 3   number of pipelined FFT stages sequenced
//  FRAME_CYC = 32  input beats per FFT frame; per-stage index counts 0..FRAME_CYC-1
//  STAGE_LAT = 2   cycles of datapath latency between consecutive stage enables
//  CNT_W     = $clog2(FRAME_CYC), localparam, index width
// PORTS
//  clk        in   1               clock
//  rstn       in   1               async active-low reset
//  start      in   1               pulse: open a new frame
//  abort      in   1               sync: kill current frame, flush enables
//  din_valid  in   1               input beat available
//  din_ready  out  1               sequencer accepts beat (valid&&ready = accept)
//  stg_en     out  NSTAGE          per-stage enable (feeds mul_en of each stage)
//  seg_idx    out  NSTAGE*CNT_W    per-stage beat index; stage k in [k*CNT_W +: CNT_W]
//  out_valid  out  1               last-stage result valid (stg_en[NSTAGE-1] delayed 1)
//  frame_done out  1               1-cycle pulse: final beat left last stage
//  busy       out  1               state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0: din_ready, stg_en, seg_idx, out_valid,
//   frame_done, busy. Delay line, counters and start_pend are also 0.
//  FSM IDLE -> LOAD on start.
//  LOAD: din_ready=1. in_cnt increments on each accept.
//   The accept with in_cnt==FRAME_CYC-1 moves to DRAIN and sets din_ready=0
//   in the next cycle.
//  DRAIN: din_ready=0. Exit to IDLE the cycle the enable delay line and out_valid
//   are all 0.
//  stg_en[0]: registered accept, high exactly one cycle after each accepted beat.
//  stg_en[k] = stg_en[0] delayed k*STAGE_LAT cycles through a shift register.
//   Bubbles (din_valid=0 in LOAD) propagate unchanged. No stall backpressure downstream.
//  seg_idx[k]: increments on each cycle stg_en[k]=1 and wraps FRAME_CYC-1 -> 0.
//   Holds during bubbles. Value is valid in the same cycle as stg_en[k].
//  frame_done is registered. It fires the cycle after
//   stg_en[NSTAGE-1]=1 && seg_idx[NSTAGE-1]==FRAME_CYC-1.
//  Fill latency: first accept to first out_valid = 2+(NSTAGE-1)*STAGE_LAT cycles (6 default).
//  start while busy: ignored (no pending latch) unless the macro below is set.
//  abort takes priority over start and accept. Next cycle: state=IDLE;
//   stg_en, delay line, in_cnt and seg_idx are all 0. No frame_done pulse.
//  rstn asserted mid-frame: async clear to reset values. No partial frame_done.
//  start and abort in the same cycle: abort wins, start discarded.
// CONFIGURATION
//  FFT_SEQ_BACK2BACK_EN defined:
//   - start during LOAD/DRAIN sets start_pend.
//   - The final accept of a frame with start_pend=1 (or start that cycle) goes
//     LOAD -> LOAD. in_cnt wraps to 0, din_ready stays 1, start_pend clears.
//   - The enable train runs gap-free; seg_idx wraps continuously.
//   - One frame_done per frame.
//  FFT_SEQ_BACK2BACK_EN undefined: no start_pend. start is honoured only in IDLE.
//   Frames are separated by a full drain.
// TESTING (defaults NSTAGE=3, FRAME_CYC=32, STAGE_LAT=2)
//  T1 reset: hold rstn=0, toggle all inputs -> all outputs 0, din_ready=0, busy=0.
//  T2 start, then 32 back-to-back valid beats:
//   - stg_en[0] high for 32 cycles starting 1 cycle after the first accept.
//   - stg_en[2] high for 32 cycles starting 5 cycles after the first accept.
//   - seg_idx[2] runs 0..31; single frame_done; busy=0 the cycle after DRAIN empties.
//  T3 din_valid low for 3 cycles after beat 10:
//   - 3-cycle hole in every stg_en.
//   - seg_idx[k] holds 10 across the hole; total enables per stage still 32.
//  T4 start pulsed at beat 15 (macro off) -> ignored: one frame, then IDLE.
//   Macro on -> beat 32 accepted with no gap, seg_idx[0] wraps 31->0,
//   two frame_done pulses 32 cycles apart.
//  T5 abort at beat 20 -> next cycle stg_en=0, seg_idx=0, IDLE, din_ready=0.
//   No frame_done; a following start gives a clean 32-beat frame.
//  T6 rstn low for 1 cycle at beat 25 -> immediate clear.
//   After release: no frame_done, busy=0, outputs idle until the next start.

Source files
------------

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_stage_sequencer
// Purpose  : frame sequencer for the pipelined FFT; per-stage enable train,
//            per-stage beat index and frame completion pulse.
//            Optional back-to-back frames: define FFT_SEQ_BACK2BACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
  parameter int  NSTAGE    = 3,
  parameter int  FRAME_CYC = 32,
  parameter int  STAGE_LAT = 2,
  localparam int CNT_W     = $clog2(FRAME_CYC)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic                    din_valid_i,
  output logic                    din_ready_o,
  output logic [NSTAGE-1:0]       stg_en_o,
  output logic [NSTAGE*CNT_W-1:0] seg_idx_o,
  output logic                    out_valid_o,
  output logic                    frame_done_o,
  output logic                    busy_o
);

  localparam int               LAT     = (NSTAGE - 1) * STAGE_LAT;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] in_cnt_q;
  logic [LAT:0]     en_q;
  logic             out_valid_q;
  logic             frame_done_q;
  logic             accept;
  logic             last_accept;
  logic             drain_empty;
  logic             start_chain;

  assign accept      = (state_q == S_LOAD) && din_valid_i;
  assign last_accept = accept && (in_cnt_q == CNT_MAX);
  // Pipeline is empty once no enable is in flight and the last result has left.
  assign drain_empty = ~|en_q && !out_valid_q;

`ifdef FFT_SEQ_BACK2BACK_EN
  logic start_pend_q;

  assign start_chain = start_pend_q || start_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_pend_q <= 1'b0;
    end else if (abort_i) begin
      start_pend_q <= 1'b0;
    end else if (last_accept || ((state_q == S_DRAIN) && drain_empty)) begin
      start_pend_q <= 1'b0;
    end else if (start_i && (state_q != S_IDLE)) begin
      start_pend_q <= 1'b1;
    end
  end
`else
  assign start_chain = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_LOAD;
        S_LOAD:  if (last_accept && !start_chain) state_d = S_DRAIN;
        S_DRAIN: if (drain_empty) state_d = start_chain ? S_LOAD : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    din_ready_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      S_LOAD: begin
        din_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      S_DRAIN: busy_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt_q     <= '0;
      en_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (abort_i) begin
      in_cnt_q     <= '0;
      en_q         <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (accept) begin
        in_cnt_q <= (in_cnt_q == CNT_MAX) ? '0 : in_cnt_q + CNT_W'(1);
      end
      en_q[0] <= accept;
      for (int i = 1; i <= LAT; i++) begin
        en_q[i] <= en_q[i-1];
      end
      out_valid_q  <= stg_en_o[NSTAGE-1];
      frame_done_o_calc: frame_done_q <= stg_en_o[NSTAGE-1] &&
                                         (seg_idx_o[(NSTAGE-1)*CNT_W +: CNT_W] == CNT_MAX);
    end
  end

  assign out_valid_o  = out_valid_q;
  assign frame_done_o = frame_done_q;

  genvar k;
  generate
    for (k = 0; k < NSTAGE; k++) begin : g_stage
      logic [CNT_W-1:0] seg_q;

      // Each stage taps the shared enable line k*STAGE_LAT cycles after stage 0.
      assign stg_en_o[k]                  = en_q[k*STAGE_LAT];
      assign seg_idx_o[k*CNT_W +: CNT_W] = seg_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          seg_q <= '0;
        end else if (abort_i) begin
          seg_q <= '0;
        end else if (stg_en_o[k]) begin
          seg_q <= (seg_q == CNT_MAX) ? '0 : seg_q + CNT_W'(1);
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
